fc_layer_seq: RTL and testbench

- Sequenced, parametrised fully-connected layer for the SNN_FC datapath.
- Consumes one input activation per handshake beat and drives the weight-memory address for that beat.
- Multiplies the beat against OUTPUT_NODES weight lanes in parallel and accumulates over INPUT_NODES beats at full precision.
- Emits one rounded, saturated Q-format result vector per frame over a valid/ready output handshake, so it replaces a bank of free-running multiply-accumulate elements with a frame-aware engine.

---
 rtl/fc_layer_seq.sv | 115 +++++++++++
 tb/tb_fc_layer_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_seq.sv
// Frame-sequenced fully-connected layer: one activation per beat against OUTPUT_NODES weight lanes,
// with full-precision accumulation, then a rounded and saturated result. Define FC_RELU_EN for ReLU.
module fc_layer_seq #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned FRAC         = 17,
  parameter int unsigned INPUT_NODES  = 20,
  parameter int unsigned OUTPUT_NODES = 10,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_data,
  output logic [ADDR_W-1:0]                    w_addr,
  input  logic [OUTPUT_NODES-1:0][WIDTH-1:0]   weights_array,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUTPUT_NODES-1:0][WIDTH-1:0]   output_fc,
  output logic                                 sat_flag,
  output logic                                 busy
);

  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(INPUT_NODES);
  localparam logic signed [ACC_W-1:0] Half = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MaxV = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MinV = -MaxV - ACC_W'(1);

  typedef enum logic [2:0] {StIdle, StAccum, StFlush, StRound, StHold} state_e;

  state_e                              state_q;
  logic [ADDR_W-1:0]                   cnt_q;
  logic [WIDTH-1:0]                    data_q;
  logic                                acc_en_q;
  logic                                first_q;
  logic signed [ACC_W-1:0]             acc_q [OUTPUT_NODES];
  logic signed [ACC_W-1:0]             acc_d [OUTPUT_NODES];
  logic signed [2*WIDTH-1:0]           prod  [OUTPUT_NODES];
  logic signed [ACC_W-1:0]             rnd   [OUTPUT_NODES];
  logic [OUTPUT_NODES-1:0][WIDTH-1:0]  res_d;
  logic                                sat_d;
  logic                                accept;
  logic                                last_beat;

  // Gated by reset so no beat is ever consumed while the block is held in reset.
  assign in_ready  = reset && (state_q == StIdle || state_q == StAccum);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == ADDR_W'(INPUT_NODES - 1));
  assign w_addr    = cnt_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    sat_d = 1'b0;
    for (int i = 0; i < OUTPUT_NODES; i++) begin
      prod[i]  = (2 * WIDTH)'($signed(data_q)) * (2 * WIDTH)'($signed(weights_array[i]));
      // The first beat of a frame overwrites, so no end-of-frame clear is needed.
      acc_d[i] = first_q ? ACC_W'(prod[i]) : acc_q[i] + ACC_W'(prod[i]);
      rnd[i]   = (acc_q[i] + Half) >>> FRAC;
      res_d[i] = rnd[i][WIDTH-1:0];
      if (rnd[i] > MaxV) begin
        res_d[i] = MaxV[WIDTH-1:0];
        sat_d    = 1'b1;
      end else if (rnd[i] < MinV) begin
        res_d[i] = MinV[WIDTH-1:0];
        sat_d    = 1'b1;
      end
`ifdef FC_RELU_EN
      if (rnd[i][ACC_W-1]) res_d[i] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      acc_en_q  <= 1'b0;
      first_q   <= 1'b0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      output_fc <= '0;
      for (int i = 0; i < OUTPUT_NODES; i++) acc_q[i] <= '0;
    end else begin
      acc_en_q <= accept;
      first_q  <= accept && (cnt_q == '0);
      if (accept) begin
        data_q <= in_data;
        cnt_q  <= last_beat ? '0 : cnt_q + 1'b1;
      end
      if (acc_en_q) begin
        for (int i = 0; i < OUTPUT_NODES; i++) acc_q[i] <= acc_d[i];
      end
      unique case (state_q)
        StIdle:  if (accept) state_q <= last_beat ? StFlush : StAccum;
        StAccum: if (accept && last_beat) state_q <= StFlush;
        StFlush: state_q <= StRound;
        StRound: begin
          output_fc <= res_d;
          sat_flag  <= sat_d;
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: default 20-beat instance plus a single-beat instance for rounding.
module tb_fc_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic iv0, ir0, ov0, or0, sf0, bz0;
  logic [23:0] id0;
  logic [9:0] wa0;
  logic [9:0][23:0] w0, of0;
  logic iv1, ir1, ov1, or1, sf1, bz1;
  logic [23:0] id1, w1_val;
  logic [9:0] wa1;
  logic [9:0][23:0] w1, of1;

  fc_layer_seq u0 (
    .clk(clk), .reset(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .w_addr(wa0),
    .weights_array(w0), .out_valid(ov0), .out_ready(or0), .output_fc(of0), .sat_flag(sf0),
    .busy(bz0)
  );

  fc_layer_seq #(.INPUT_NODES(1)) u1 (
    .clk(clk), .reset(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .w_addr(wa1),
    .weights_array(w1), .out_valid(ov1), .out_ready(or1), .output_fc(of1), .sat_flag(sf1),
    .busy(bz1)
  );

  int mode;

  function automatic logic [23:0] wgt(input int m, input int i);
    case (m)
      0:       wgt = 24'h010000;
      1:       wgt = 24'((i - 5) * 131072);
      default: wgt = 24'hFF8000;
    endcase
  endfunction

  // Synchronous weight ROMs: row appears one cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 10; i++) w0[i] <= wgt(mode, i);
    w1 <= {10{w1_val}};
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  bit addr_ok;
  int sent;

  task automatic send_frame(input logic [23:0] din, input bit gaps);
    int cyc = 0;
    bit ph = 1'b0;
    sent = 0;
    addr_ok = 1'b1;
    while (sent < 20 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      iv0 = gaps ? ph : 1'b1;
      ph  = !ph;
      id0 = din;
      if (iv0 && ir0) begin
        if (wa0 != 10'(sent)) addr_ok = 1'b0;
        sent++;
      end
    end
  endtask

  task automatic wait_out0(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      iv0 = 1'b0;
      lat++;
    end while (!ov0 && lat < 50);
  endtask

  typedef struct packed {
    logic [1:0]       mode;
    logic [23:0]      din;
    logic             gaps;
    logic [9:0][23:0] exp;
    logic             exp_sat;
  } vec_t;

  typedef struct packed {
    logic [23:0] din;
    logic [23:0] w;
    logic [23:0] exp;
    logic        exp_sat;
  } vec1_t;

  vec_t  vecs [4];
  vec1_t vecs1 [6];

  initial begin
    int lat;
    bit ok;
    logic [9:0][23:0] ten;

    for (int i = 0; i < 10; i++) ten[i] = 24'h140000;
    vecs[0] = '{mode: 2'd0, din: 24'h020000, gaps: 1'b0, exp: ten, exp_sat: 1'b0};
    vecs[2] = '{mode: 2'd0, din: 24'h020000, gaps: 1'b1, exp: ten, exp_sat: 1'b0};
    vecs[1].mode = 2'd1; vecs[1].din = 24'h020000; vecs[1].gaps = 1'b0; vecs[1].exp_sat = 1'b1;
`ifdef FC_RELU_EN
    for (int i = 0; i < 5; i++) vecs[1].exp[i] = 24'h000000;
`else
    vecs[1].exp[0] = 24'h800000; vecs[1].exp[1] = 24'h800000; vecs[1].exp[2] = 24'h880000;
    vecs[1].exp[3] = 24'hB00000; vecs[1].exp[4] = 24'hD80000;
`endif
    vecs[1].exp[5] = 24'h000000; vecs[1].exp[6] = 24'h280000; vecs[1].exp[7] = 24'h500000;
    vecs[1].exp[8] = 24'h780000; vecs[1].exp[9] = 24'h7FFFFF;
    vecs[3].mode = 2'd2; vecs[3].din = 24'h010000; vecs[3].gaps = 1'b0; vecs[3].exp_sat = 1'b0;
`ifdef FC_RELU_EN
    for (int i = 0; i < 10; i++) vecs[3].exp[i] = 24'h000000;
`else
    for (int i = 0; i < 10; i++) vecs[3].exp[i] = 24'hFB0000;
`endif

    vecs1[0] = '{din: 24'h000001, w: 24'h010000, exp: 24'h000001, exp_sat: 1'b0};
    vecs1[1] = '{din: 24'h000001, w: 24'h00FFFF, exp: 24'h000000, exp_sat: 1'b0};
    vecs1[2] = '{din: 24'h000003, w: 24'h010000, exp: 24'h000002, exp_sat: 1'b0};
    vecs1[3] = '{din: 24'hFFFFFF, w: 24'h010000, exp: 24'h000000, exp_sat: 1'b0};
`ifdef FC_RELU_EN
    vecs1[4] = '{din: 24'hFFFFFD, w: 24'h010000, exp: 24'h000000, exp_sat: 1'b0};
`else
    vecs1[4] = '{din: 24'hFFFFFD, w: 24'h010000, exp: 24'hFFFFFF, exp_sat: 1'b0};
`endif
    vecs1[5] = '{din: 24'h7FFFFF, w: 24'h7FFFFF, exp: 24'h7FFFFF, exp_sat: 1'b1};

    mode = 0; rst_n = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b1; w1_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_w_addr", wa0, 0);
    chk("rst_sat", sf0, 0);
    chk("rst_output_fc", of0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready_after", ir0, 1);

    for (int v = 0; v < 4; v++) begin
      mode = int'(vecs[v].mode);
      send_frame(vecs[v].din, vecs[v].gaps);
      chk($sformatf("vec%0d_beats", v), sent, 20);
      chk($sformatf("vec%0d_waddr_seq", v), addr_ok, 1);
      wait_out0(lat);
      chk($sformatf("vec%0d_latency", v), lat, 3);
      chk($sformatf("vec%0d_lanes", v), of0, vecs[v].exp);
      chk($sformatf("vec%0d_sat", v), sf0, vecs[v].exp_sat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_drop", v), ov0, 0);
      chk($sformatf("vec%0d_ready_back", v), ir0, 1);
    end

    // Backpressure: result held, beats offered meanwhile must be ignored.
    mode = 0; or0 = 1'b0;
    send_frame(24'h020000, 1'b0);
    wait_out0(lat);
    chk("bp_latency", lat, 3);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      iv0 = 1'b1; id0 = 24'h7FFFFF;
      @(posedge clk); #1;
      if (ir0 !== 1'b0 || ov0 !== 1'b1 || of0 !== ten || wa0 !== 10'd0 || sf0 !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold_stable", ok, 1);
    or0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    chk("bp_valid_drop", ov0, 0);
    chk("bp_ready_back", ir0, 1);
    send_frame(24'h020000, 1'b0);
    wait_out0(lat);
    chk("bp_next_frame", of0, ten);
    @(posedge clk); #1;

    // Reset mid-frame after a completed frame left a nonzero result behind.
    for (int c = 0; c < 7; c++) begin
      iv0 = 1'b1; id0 = 24'h7FFFFF;
      @(posedge clk); #1;
    end
    iv0 = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", ov0, 0);
    chk("mid_rst_busy", bz0, 0);
    chk("mid_rst_w_addr", wa0, 0);
    chk("mid_rst_output_fc", of0, 0);
    chk("mid_rst_sat", sf0, 0);
    chk("mid_rst_in_ready", ir0, 0);
    rst_n = 1'b1;
    send_frame(24'h020000, 1'b0);
    chk("mid_rst_waddr_seq", addr_ok, 1);
    wait_out0(lat);
    chk("mid_rst_latency", lat, 3);
    chk("mid_rst_lanes", of0, ten);
    @(posedge clk); #1;

    // Single-beat instance: rounding, negative rounding and saturation.
    for (int v = 0; v < 6; v++) begin
      lat = 0;
      iv1 = 1'b1; id1 = vecs1[v].din; w1_val = vecs1[v].w;
      while (!ir1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("n1_vec%0d_ready", v), ir1, 1);
      lat = 0;
      do begin
        @(posedge clk); #1;
        iv1 = 1'b0;
        lat++;
      end while (!ov1 && lat < 50);
      chk($sformatf("n1_vec%0d_latency", v), lat, 3);
      chk($sformatf("n1_vec%0d_lanes", v), of1, {10{vecs1[v].exp}});
      chk($sformatf("n1_vec%0d_sat", v), sf1, vecs1[v].exp_sat);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
